// File: rtl/fpu_f2i_conv.sv
// fpu_f2i_conv
//   Two-stage pipelined IEEE-754 single precision to signed fixed-point
//   converter. Round-to-nearest-even, saturation on overflow or +/-Inf,
//   NaN reported as zero with o_nan set, denormals flushed to zero.
//
//   Parameters
//     FIX_W   total fixed-point width (16..32)
//     FRAC_W  fractional bits of the output (0..FIX_W-1)
//
//   Ports
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_valid / o_ready     input handshake, i_32_a is the float word
//     o_valid / i_ready     output handshake
//     o_fix                 signed fixed-point result
//     o_ovf                 result saturated (out of range or Inf)
//     o_nan                 input was NaN, o_fix = 0
//     o_inexact             nonzero bits were discarded by rounding
//     o_sat_cnt             saturating count of outputs with o_ovf|o_nan
//                           (only when FPU_F2I_SAT_CNT_EN is defined)
//
//   Optional feature macro: FPU_F2I_SAT_CNT_EN

module fpu_f2i_conv #(
  parameter int FIX_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_32_a,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [FIX_W-1:0] o_fix,
  output logic             o_ovf,
  output logic             o_nan,
  output logic             o_inexact
`ifdef FPU_F2I_SAT_CNT_EN
  ,
  output logic [15:0]      o_sat_cnt
`endif
);

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } cls_t;

  localparam logic [63:0]      LIM     = 64'd1 << (FIX_W - 1);
  localparam logic [FIX_W-1:0] FIX_MAX = {1'b0, {(FIX_W-1){1'b1}}};
  localparam logic [FIX_W-1:0] FIX_MIN = {1'b1, {(FIX_W-1){1'b0}}};

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic s1_valid;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv  = ~o_valid | i_ready;
  assign s1_adv  = ~s1_valid | s2_adv;
  assign o_ready = s1_adv;

  // ---------------------------------------------------------------------
  // Stage 1: decode
  // ---------------------------------------------------------------------
  logic [7:0]        in_exp;
  logic [22:0]       in_frac;
  cls_t              in_cls;
  logic signed [9:0] in_sh;

  assign in_exp  = i_32_a[30:23];
  assign in_frac = i_32_a[22:0];

  always_comb begin
    in_cls = CLS_NORM;
    if (in_exp == 8'h00) begin
      in_cls = CLS_ZERO;
    end else if (in_exp == 8'hFF) begin
      in_cls = (in_frac == '0) ? CLS_INF : CLS_NAN;
    end
  end

  // Left-shift amount that places the mantissa LSB at the output LSB.
  assign in_sh = $signed({2'b00, in_exp}) - 10'sd150 + $signed(10'(FRAC_W));

  logic              s1_sign;
  logic [23:0]       s1_man;
  logic signed [9:0] s1_sh;
  cls_t              s1_cls;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_man   <= '0;
      s1_sh    <= '0;
      s1_cls   <= CLS_ZERO;
    end else if (s1_adv) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_sign <= i_32_a[31];
        s1_man  <= {1'b1, in_frac};
        s1_sh   <= in_sh;
        s1_cls  <= in_cls;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: shift, round, saturate
  // ---------------------------------------------------------------------
  logic [25:0] man26;
  logic [25:0] q;
  logic [25:0] rmask;
  logic [9:0]  nsh;
  logic [4:0]  nsh5;
  logic [4:0]  gidx;
  logic        guard;
  logic        sticky;
  logic        big;
  logic        sh_inx;
  logic [63:0] mag;

  assign man26 = {2'b00, s1_man};
  assign nsh   = -s1_sh;
  assign nsh5  = nsh[4:0];
  assign gidx  = nsh5 - 5'd1;

  always_comb begin
    q      = '0;
    rmask  = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    big    = 1'b0;
    sh_inx = 1'b0;
    mag    = '0;
    if (!s1_sh[9]) begin
      // Any shift past 39 is far beyond a 32-bit result: saturate directly.
      if (s1_sh > 10'sd39) begin
        big = 1'b1;
      end else begin
        mag = {40'd0, s1_man} << s1_sh[5:0];
      end
    end else if (nsh > 10'd25) begin
      sh_inx = 1'b1;
    end else begin
      q      = man26 >> nsh5;
      guard  = man26[gidx];
      rmask  = (26'd1 << gidx) - 26'd1;
      sticky = |(man26 & rmask);
      mag    = {38'd0, q} + {63'd0, guard & (sticky | q[0])};
      sh_inx = guard | sticky;
    end
  end

  logic [FIX_W-1:0] r_fix;
  logic             r_ovf;
  logic             r_nan;
  logic             r_inx;

  always_comb begin
    r_fix = '0;
    r_ovf = 1'b0;
    r_nan = 1'b0;
    r_inx = 1'b0;
    unique case (s1_cls)
      CLS_NAN: begin
        r_nan = 1'b1;
      end
      CLS_INF: begin
        r_ovf = 1'b1;
        r_fix = s1_sign ? FIX_MIN : FIX_MAX;
      end
      CLS_NORM: begin
        // Rounding carry is covered here since mag already includes it.
        if (big || (mag > LIM) || ((mag == LIM) && !s1_sign)) begin
          r_ovf = 1'b1;
          r_fix = s1_sign ? FIX_MIN : FIX_MAX;
        end else begin
          r_inx = sh_inx;
          r_fix = s1_sign ? -mag[FIX_W-1:0] : mag[FIX_W-1:0];
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid   <= 1'b0;
      o_fix     <= '0;
      o_ovf     <= 1'b0;
      o_nan     <= 1'b0;
      o_inexact <= 1'b0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_fix     <= r_fix;
        o_ovf     <= r_ovf;
        o_nan     <= r_nan;
        o_inexact <= r_inx;
      end
    end
  end

`ifdef FPU_F2I_SAT_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sat_cnt <= '0;
    end else if (o_valid && i_ready && (o_ovf || o_nan) && (o_sat_cnt != '1)) begin
      o_sat_cnt <= o_sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_f2i_conv.sv
// Bench for fpu_f2i_conv: real-arithmetic reference model, scoreboard queue
// and one compare process sampling on the falling clock edge.
module tb_fpu_f2i_conv;

  localparam int FIX_W  = 32;
  localparam int FRAC_W = 16;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_32_a;
  logic             o_valid;
  logic             i_ready;
  logic [FIX_W-1:0] o_fix;
  logic             o_ovf;
  logic             o_nan;
  logic             o_inexact;
`ifdef FPU_F2I_SAT_CNT_EN
  logic [15:0]      o_sat_cnt;
`endif

  fpu_f2i_conv #(.FIX_W(FIX_W), .FRAC_W(FRAC_W)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_32_a    (i_32_a),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_fix     (o_fix),
    .o_ovf     (o_ovf),
    .o_nan     (o_nan),
    .o_inexact (o_inexact)
`ifdef FPU_F2I_SAT_CNT_EN
    ,
    .o_sat_cnt (o_sat_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt = 0;
  bit lat_exact = 1'b0;

  typedef struct packed {
    logic [FIX_W-1:0] fix;
    logic             ovf;
    logic             nan;
    logic             inx;
    int               cyc;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Reference: exact value scaled by 2^FRAC_W, then round-half-even and clamp.
  function automatic exp_t model(input logic [31:0] a);
    exp_t   r;
    logic   s;
    int     e;
    logic [22:0] f;
    real    v, fl, fr;
    longint m, lim;
    r = '0;
    s = a[31];
    e = int'(a[30:23]);
    f = a[22:0];
    lim = longint'(1) << (FIX_W - 1);
    if (e == 255 && f != 0) begin
      r.nan = 1'b1;
    end else if (e == 255) begin
      r.ovf = 1'b1;
      r.fix = s ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
    end else if (e != 0) begin
      v = $itor({8'd0, 1'b1, f});
      for (int i = 0; i < e - 150 + FRAC_W; i++) v = v * 2.0;
      for (int i = 0; i < 150 - FRAC_W - e; i++) v = v / 2.0;
      if (v >= 1099511627776.0) begin
        r.ovf = 1'b1;
      end else begin
        fl = $floor(v);
        fr = v - fl;
        m  = longint'(fl);
        if (fr > 0.5 || (fr == 0.5 && m[0])) m = m + 1;
        r.inx = (fr != 0.0);
        if (m > lim || (m == lim && !s)) r.ovf = 1'b1;
        else r.fix = s ? -m[FIX_W-1:0] : m[FIX_W-1:0];
      end
      if (r.ovf) begin
        r.inx = 1'b0;
        r.fix = s ? {1'b1, {(FIX_W-1){1'b0}}} : {1'b0, {(FIX_W-1){1'b1}}};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_f();
    logic [7:0]  e;
    logic [22:0] f;
    logic        s;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 9))
      0: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) f = '0;
      end
      1: e = 8'h00;
      2: e = 8'($urandom_range(138, 150));
      default: e = 8'($urandom_range(100, 141));
    endcase
    if ($urandom_range(0, 3) == 0) f = f & 23'h7FFF00;
    return {s, e, f};
  endfunction

  // ---------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------
  bit               hold_v = 1'b0;
  logic [FIX_W+2:0] held;
  logic [15:0]      sat_exp = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      hold_v  = 1'b0;
      sat_exp = '0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 64'(o_valid), 64'd1);
        check("hold_data", 64'({o_fix, o_ovf, o_nan, o_inexact}), 64'(held));
      end
      hold_v = 1'b0;
`ifdef FPU_F2I_SAT_CNT_EN
      check("sat_cnt", 64'(o_sat_cnt), 64'(sat_exp));
`endif
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'(o_valid), 64'd0);
        end else begin
          e = q.pop_front();
          check("result", 64'({o_fix, o_ovf, o_nan, o_inexact}), 64'({e.fix, e.ovf, e.nan, e.inx}));
          if (lat_exact) check("latency", 64'(cyc - e.cyc), 64'd2);
          else check("latency_min", 64'((cyc - e.cyc) >= 2), 64'd1);
          if ((e.ovf || e.nan) && sat_exp != 16'hFFFF) sat_exp = sat_exp + 16'd1;
        end
      end else if (o_valid) begin
        hold_v = 1'b1;
        held   = {o_fix, o_ovf, o_nan, o_inexact};
      end
      if (i_valid && o_ready) begin
        e = model(i_32_a);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] a);
    logic acc;
    acc = 1'b0;
    i_valid = 1'b1;
    i_32_a  = a;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      acc = o_ready;
      @(posedge clk);
      #2;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got o_ready=0 want accept within 50 cycles");
    end else begin
      acc_cnt++;
    end
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  logic [31:0] vin  [11] = '{32'h3F800000, 32'hC0200000, 32'h37C00000, 32'h38200000,
                             32'h33800000, 32'h47800000, 32'hC7000000, 32'hFF800000,
                             32'h7FC00000, 32'h80000000, 32'h00400000};
  logic [31:0] vfix [11] = '{32'h00010000, 32'hFFFD8000, 32'h00000002, 32'h00000002,
                             32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                             32'h00000000, 32'h00000000, 32'h00000000};
  logic [2:0]  vflg [11] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b100,
                             3'b000, 3'b100, 3'b010, 3'b000, 3'b000};
  logic [31:0] bp_w [4]  = '{32'h3F800000, 32'h40000000, 32'hC0400000, 32'h40800000};

  initial begin
    exp_t m;
    int   base;
    rst_n   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_32_a  = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_fix", 64'(o_fix), 64'd0);
    check("rst_flags", 64'({o_ovf, o_nan, o_inexact}), 64'd0);
    check("rst_o_ready", 64'(o_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();

    // Pin the reference model to hand-computed values.
    for (int i = 0; i < 11; i++) begin
      m = model(vin[i]);
      check($sformatf("model_%08h", vin[i]), 64'({m.fix, m.ovf, m.nan, m.inx}),
            64'({vfix[i], vflg[i]}));
    end

    // Directed values through the DUT, i_ready held high.
    lat_exact = 1'b1;
    for (int i = 0; i < 11; i++) send(vin[i]);
    repeat (4) step();
    lat_exact = 1'b0;

    // Backpressure: 4 words offered with i_ready low for 5 cycles.
    base = acc_cnt;
    i_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(bp_w[i]);
      end
      begin
        repeat (4) step();
        #1;
        check("bp_o_ready_low", 64'(o_ready), 64'd0);
        check("bp_words_held", 64'(acc_cnt - base), 64'd2);
        step();
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          #1;
          check("bp_stream_valid", 64'(o_valid), 64'd1);
          @(posedge clk);
          #2;
        end
      end
    join
    repeat (4) step();
    check("bp_drained", 64'(q.size()), 64'd0);

    // Reset with two words in flight.
    i_ready = 1'b0;
    send(32'h3F800000);
    send(32'h40000000);
    rst_n = 1'b0;
    #1;
    check("midrst_o_valid", 64'(o_valid), 64'd0);
    check("midrst_o_ready", 64'(o_ready), 64'd1);
    step();
    step();
    rst_n   = 1'b1;
    i_ready = 1'b1;
    repeat (6) begin
      #1;
      check("midrst_no_stale", 64'(o_valid), 64'd0);
      @(posedge clk);
      #2;
    end
    check("midrst_o_ready_after", 64'(o_ready), 64'd1);

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_valid = ($urandom_range(0, 3) != 0);
      i_32_a  = rand_f();
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (8) step();
    check("final_drained", 64'(q.size()), 64'd0);

`ifdef FPU_F2I_SAT_CNT_EN
    do_reset();
    send(32'h47800000);
    send(32'hC7800000);
    send(32'h7F800000);
    send(32'h7FC00000);
    send(32'h3F800000);
    send(32'hC0200000);
    repeat (5) step();
    check("sat_cnt_total", 64'(o_sat_cnt), 64'd4);
`else
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
